// File: rtl/hazard_scoreboard.sv
// Hazard controller for the F/D/E/W pipeline: per-register load scoreboard,
// multi-cycle branch-flush FSM, flag interlock and operand-forward selects.
module hazard_scoreboard #(
    parameter int unsigned REG_ADDR_W     = 3,
    parameter int unsigned LOAD_LAT       = 1,
    parameter int unsigned BRANCH_PENALTY = 1,
    parameter bit          ZERO_REG_EN    = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue_D,
    input  logic [REG_ADDR_W-1:0]        rs1_D,
    input  logic [REG_ADDR_W-1:0]        rs2_D,
    input  logic [REG_ADDR_W-1:0]        rd_D,
    input  logic                         rs1_used_D,
    input  logic                         rs2_used_D,
    input  logic                         reg_write_D,
    input  logic                         mem_read_D,
    input  logic                         branch_D,
    input  logic                         flag_write_E,
    input  logic                         branch_taken_E,
    input  logic [REG_ADDR_W-1:0]        rs1_E,
    input  logic [REG_ADDR_W-1:0]        rs2_E,
    input  logic [REG_ADDR_W-1:0]        rd_W,
    input  logic                         reg_write_W,
    output logic                         stall_F,
    output logic                         stall_D,
    output logic                         flush_F,
    output logic                         flush_D,
    output logic [1:0]                   forward_A,
    output logic [1:0]                   forward_B,
    output logic                         forward_decode_A,
    output logic                         forward_decode_B,
    output logic [(2**REG_ADDR_W)-1:0]   busy_vec
);

    localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;
    localparam bit          MultiCycle = BRANCH_PENALTY > 1;
    localparam logic [1:0]  PcInit     = MultiCycle ? 2'(BRANCH_PENALTY - 2) : 2'd0;
    localparam logic [2:0]  LoadInit   = 3'(LOAD_LAT);

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    state_e     state_q;
    logic [1:0] pc_q;
    logic [2:0] cnt_q [NUM_REGS];
    logic [2:0] cnt_d [NUM_REGS];

    logic luse, fhaz, hazard, flush_br, issue_ok, load_issue, wb_ok;

    // Register 0 is invisible to the scoreboard and forwarding when hardwired.
    function automatic logic reg_live(input logic [REG_ADDR_W-1:0] r);
        return !(ZERO_REG_EN && (r == '0));
    endfunction

    // Busy bits straight from the registered counters.
    always_comb begin
        for (int n = 0; n < NUM_REGS; n++) begin
            busy_vec[n] = (cnt_q[n] != 3'd0);
        end
    end

    // Hazard detection and stall/flush priority: a branch flush wins over any stall.
    always_comb begin
        luse = issue_D & ((rs1_used_D & busy_vec[rs1_D] & reg_live(rs1_D)) |
                          (rs2_used_D & busy_vec[rs2_D] & reg_live(rs2_D)));
        fhaz     = issue_D & branch_D & flag_write_E;
        hazard   = luse | fhaz;
        flush_br = (state_q == StFlush) | branch_taken_E;
        flush_F  = flush_br;
        flush_D  = flush_br | hazard;
        stall_F  = hazard & ~flush_br;
        stall_D  = hazard & ~flush_br;
        issue_ok   = issue_D & ~stall_D & ~flush_D & (state_q == StIdle);
        load_issue = issue_ok & mem_read_D & reg_write_D & reg_live(rd_D);
    end

    // Forward selects from the W-stage result.
    always_comb begin
        wb_ok            = reg_write_W & reg_live(rd_W);
        forward_A        = {wb_ok & (rd_W == rs1_E), 1'b0};
        forward_B        = {wb_ok & (rd_W == rs2_E), 1'b0};
        forward_decode_A = wb_ok & (rd_W == rs1_D);
        forward_decode_B = wb_ok & (rd_W == rs2_D);
    end

    // Counter next state: a newly issued load reloads its register, others count down.
    always_comb begin
        for (int n = 0; n < NUM_REGS; n++) begin
            if (load_issue && (rd_D == REG_ADDR_W'(n))) begin
                cnt_d[n] = LoadInit;
            end else if (cnt_q[n] != 3'd0) begin
                cnt_d[n] = cnt_q[n] - 3'd1;
            end else begin
                cnt_d[n] = cnt_q[n];
            end
        end
    end

    // Scoreboard counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_REGS; n++) begin
                cnt_q[n] <= 3'd0;
            end
        end else begin
            for (int n = 0; n < NUM_REGS; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    // Branch-flush FSM; taken branches seen while flushing are bubbles and ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= 2'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (branch_taken_E && MultiCycle) begin
                        state_q <= StFlush;
                        pc_q    <= PcInit;
                    end
                end
                StFlush: begin
                    if (pc_q == 2'd0) begin
                        state_q <= StIdle;
                    end else begin
                        pc_q <= pc_q - 2'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard controller for the MINI-RISC F/D/E/W pipeline. It replaces purely combinational hazard detection with a per-register load scoreboard, a multi-cycle branch-flush state machine and a flag-dependency interlock. It drives the FD/DE stall and flush controls and the operand-forward selects.

## Interface
Parameters:
- REG_ADDR_W, 3: register address width; NUM_REGS = 2**REG_ADDR_W
- LOAD_LAT, 1: cycles after issue before a load result can be forwarded; 1..7
- BRANCH_PENALTY, 1: cycles of FD/DE flush after a taken branch; 1..4
- ZERO_REG_EN, 0: when 1, register 0 is hardwired zero and is never scoreboarded or forwarded

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- issue_D  in  1  valid instruction present in D
- rs1_D, rs2_D, rd_D  in  REG_ADDR_W  D-stage register fields
- rs1_used_D, rs2_used_D  in  1  operand actually read by the D instruction
- reg_write_D, mem_read_D  in  1  D instruction writes rd / is a load
- branch_D  in  1  D instruction is a conditional branch (reads flags)
- flag_write_E  in  1  E instruction is SETF/CPLF
- branch_taken_E  in  1  branch resolved taken in E
- rs1_E, rs2_E  in  REG_ADDR_W  E-stage source fields
- rd_W  in  REG_ADDR_W  W-stage destination
- reg_write_W  in  1  W instruction writes rd
- stall_F, stall_D  out  1  hold FD / DE registers
- flush_F, flush_D  out  1  clear FD / DE registers (bubble)
- forward_A, forward_B  out  2  E operand select: 00 register file, 10 W result
- forward_decode_A, forward_decode_B  out  1  D operand taken from W result
- busy_vec  out  NUM_REGS  bit n set while cnt[n] != 0

## Operation
- Scoreboard: cnt[NUM_REGS], each 3 bits. Issue = issue_D & ~stall_D & ~flush_D & (state == IDLE).
- On issue with mem_read_D & reg_write_D (and rd_D != 0 when ZERO_REG_EN): cnt[rd_D] <= LOAD_LAT. All other non-zero counters decrement by 1 per cycle. A load reissuing to the same register overrides its decrement.
- Load-use: luse = issue_D & ((rs1_used_D & cnt[rs1_D] != 0) | (rs2_used_D & cnt[rs2_D] != 0)). Register 0 is excluded when ZERO_REG_EN.
- Flag interlock: fhaz = issue_D & branch_D & flag_write_E.
- On luse | fhaz: stall_F = stall_D = 1 and flush_D = 1, inserting a bubble into E.
- Branch FSM:
  - States are IDLE and FLUSH, with a penalty counter pc of 2 bits.
  - IDLE & branch_taken_E: flush_F = flush_D = 1 this cycle. If BRANCH_PENALTY > 1, go to FLUSH with pc = BRANCH_PENALTY-2; otherwise stay in IDLE.
  - FLUSH: flush_F = flush_D = 1. If pc == 0, go to IDLE; else decrement pc.
  - branch_taken_E while in FLUSH is ignored; the instruction in E is a bubble.
- Priority: flush beats stall. When flush_F is set, stall_F = stall_D = 0.
- Forwarding (combinational, gated by reg_write_W, and by rd_W != 0 when ZERO_REG_EN):
  - forward_A = 10 iff rd_W == rs1_E; forward_B likewise for rs2_E.
  - forward_decode_A/B = 1 iff rd_W == rs1_D / rs2_D.

## Timing
- Reset (rst_n low, asynchronous): all cnt = 0, state IDLE, pc = 0. All outputs are 0 while in reset and on the first cycle after release, given idle inputs.
- Outputs are Mealy: registered state plus same-cycle inputs, with zero-cycle latency.
- Load at cycle t to r3, LOAD_LAT = 1: cnt[3] = 1 during t+1, so a consumer in D at t+1 stalls one cycle. The stall clears at t+2 (cnt = 0).
- A dependent load chain adds LOAD_LAT stall cycles per link.
- Reset asserted mid-FLUSH or mid-stall aborts immediately; the pipeline resumes unstalled after release.
- busy_vec reflects the registered counters and is updated on the edge after issue.

## Test plan
- Reset release, random D/E/W fields with all valid/write inputs 0 -> every output 0 and busy_vec = 0 for 20 cycles.
- LOAD r3 issued, then ADD using rs1 = r3 next cycle, LOAD_LAT = 1 -> one cycle of stall_F = stall_D = flush_D = 1, busy_vec[3] high for one cycle.
- Repeat with LOAD_LAT = 3 -> three stall cycles. Load to r5 with an independent r2 consumer -> no stall.
- branch_taken_E pulse with BRANCH_PENALTY = 2 -> flush_F = flush_D = 1 for exactly 2 cycles. A second branch_taken_E in cycle 2 -> no extension.
- SETF in E and branch in D -> one stall cycle. Simultaneous load-use and branch_taken_E -> flush only, stall_F = 0.
- ZERO_REG_EN = 1, reg_write_W with rd_W = 0 = rs1_E -> forward_A = 00. rd_W = 4 = rs2_E -> forward_B = 10.
